// File: rtl/key_debounce_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_debounce_n                                             |
// | Description : Multi-channel key debouncer. Each active-low key input is  |
// |               synchronised, then sampled on a shared prescaler tick. A   |
// |               level change is accepted after STABLE_CNT agreeing         |
// |               samples. A per-key hold FSM produces a long-press pulse    |
// |               followed by periodic auto-repeat pulses.                   |
// | Ports       : clk           - system clock, rising edge                  |
// |               rst           - asynchronous active-high reset             |
// |               key           - raw key inputs, 0 = pressed                |
// |               key_level     - debounced state, 1 = pressed               |
// |               press_pulse   - one-clk pulse on accepted press            |
// |               release_pulse - one-clk pulse on accepted release          |
// |               long_pulse    - one-clk pulse when hold hits LONG_TICKS    |
// |               repeat_pulse  - one-clk pulse every REPEAT_TICKS after     |
// |               sample_tick   - one-clk strobe per sample instant          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module key_debounce_n #(
  parameter int N_KEYS       = 3,
  parameter int SAMPLE_DIV   = 1048576,
  parameter int STABLE_CNT   = 4,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              sample_tick
);

  localparam int c_DIV_W    = $clog2(SAMPLE_DIV);
  localparam int c_STAB_W   = $clog2(STABLE_CNT + 1);
  localparam int c_HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SAMPLE_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_PRE   = c_DIV_W'(SAMPLE_DIV - 2);
  localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(STABLE_CNT - 1);
  localparam logic [c_HOLD_W-1:0] c_LONG_LAST = c_HOLD_W'(LONG_TICKS - 1);
  localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_t;

  // Two-flop synchronisers; reset to 1 so keys read as released.
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // Shared prescaler. The tick flop is loaded one count early so that it is
  // high exactly while the counter holds SAMPLE_DIV-1, and still registered.
  logic [c_DIV_W-1:0] r_div;
  logic               r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
      r_tick <= (r_div == c_DIV_PRE);
    end
  end

  assign sample_tick = r_tick;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [c_STAB_W-1:0] r_stab;
    logic                r_level;
    logic                r_press;
    logic                r_rel;
    logic                w_pressed;
    logic                w_differ;
    logic                w_toggle;
    logic                w_acc_press;
    logic                w_acc_rel;

    assign w_pressed   = ~r_sync2[i];
    assign w_differ    = w_pressed ^ r_level;
    assign w_toggle    = r_tick & w_differ & (r_stab == c_STAB_LAST);
    assign w_acc_press = w_toggle & ~r_level;
    assign w_acc_rel   = w_toggle & r_level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_stab  <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_press <= w_acc_press;
        r_rel   <= w_acc_rel;
        if (r_tick) begin
          if (!w_differ) begin
            r_stab <= '0;
          end else if (r_stab == c_STAB_LAST) begin
            r_stab  <= '0;
            r_level <= ~r_level;
          end else begin
            r_stab <= r_stab + 1'b1;
          end
        end
      end
    end

    // Hold FSM: counts ticks while pressed; release always wins.
    hold_state_t         r_state;
    hold_state_t         w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_long_nxt;
    logic                w_rep_nxt;
    logic                r_long;
    logic                r_rep;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_hold  <= '0;
        r_long  <= 1'b0;
        r_rep   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_long  <= w_long_nxt;
        r_rep   <= w_rep_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_long_nxt  = 1'b0;
      w_rep_nxt   = 1'b0;
      if (w_acc_rel) begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end else if (r_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_acc_press) begin
              w_state_nxt = ST_HELD;
              w_hold_nxt  = '0;
            end
          end
          ST_HELD: begin
            if (r_hold == c_LONG_LAST) begin
              w_long_nxt  = 1'b1;
              w_state_nxt = ST_REPEAT;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_hold == c_REP_LAST) begin
              w_rep_nxt  = 1'b1;
              w_hold_nxt = '0;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
          end
        endcase
      end
    end

    assign key_level[i]     = r_level;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_rel;
    assign long_pulse[i]    = r_long;
    assign repeat_pulse[i]  = r_rep;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce_n.md
KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 SHALL have parameter N_KEYS, default 3, meaning the number of independent key channels (1..32).
REQ-002 SHALL have parameter SAMPLE_DIV, default 1048576, meaning the clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE_CNT, default 4, meaning the consecutive agreeing samples needed to accept a level change (>=1).
REQ-004 SHALL have parameter LONG_TICKS, default 100, meaning the sample ticks a key must be held before long_pulse (>=1).
REQ-005 SHALL have parameter REPEAT_TICKS, default 20, meaning the sample ticks between repeat_pulse outputs after long press (>=1).
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port key, input, N_KEYS bits: raw asynchronous key inputs, active-low (0 = pressed).
REQ-009 SHALL have port key_level, output, N_KEYS bits: debounced state, 1 = pressed.
REQ-010 SHALL have port press_pulse, output, N_KEYS bits: one-clk pulse on an accepted press.
REQ-011 SHALL have port release_pulse, output, N_KEYS bits: one-clk pulse on an accepted release.
REQ-012 SHALL have port long_pulse, output, N_KEYS bits: one-clk pulse when the hold reaches LONG_TICKS.
REQ-013 SHALL have port repeat_pulse, output, N_KEYS bits: one-clk auto-repeat pulse during a long hold.
REQ-014 SHALL have port sample_tick, output, 1 bit: one-clk strobe marking each sample instant.

Function
REQ-015 SHALL pass each key bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL run one shared prescaler counting 0..SAMPLE_DIV-1, wrapping to 0, and assert sample_tick for exactly the one cycle the count equals SAMPLE_DIV-1.
REQ-017 SHALL size every counter with $clog2 of its terminal value, with no overflow at any legal parameter value.
REQ-018 SHALL, per key on each tick, increment a stable counter when the synchronized pressed value differs from key_level, and clear it when the value equals key_level.
REQ-019 SHALL toggle key_level when the stable counter reaches STABLE_CNT, clear the counter, and place the new level on the output in the cycle after that tick.
REQ-020 SHALL assert press_pulse (or release_pulse) in exactly the first cycle key_level shows 1 (or 0), and never assert both for one key in the same cycle.
REQ-021 SHALL run a per-key hold FSM with states IDLE, HELD and REPEAT, each with a hold counter that increments only on ticks.
REQ-022 SHALL move IDLE->HELD with the hold counter at 0 on an accepted press.
REQ-023 SHALL, in HELD, assert long_pulse and move to REPEAT with the counter at 0 on the tick where the counter reaches LONG_TICKS.
REQ-024 SHALL, in REPEAT, assert repeat_pulse and clear the counter on the tick where the counter reaches REPEAT_TICKS, and continue doing so indefinitely.
REQ-025 SHALL move any state to IDLE on an accepted release; a release on the same tick as a long or repeat event takes priority and suppresses that pulse.
REQ-026 SHALL keep channels fully independent; pulses on several keys in the same cycle are legal.
REQ-027 SHALL register all outputs (no combinational path from key to any output).

Reset
REQ-028 SHALL, while rst=1, hold the prescaler, stable and hold counters at 0, the synchronizers at 1 (released), the FSMs in IDLE, and every output at 0.
REQ-029 SHALL generate no press_pulse or release_pulse on reset deassertion, even with keys held, until STABLE_CNT qualifying ticks have elapsed.
REQ-030 SHALL, when rst asserts mid-hold, return to the reset state immediately without emitting release_pulse.

Verification (N_KEYS=3, SAMPLE_DIV=4, STABLE_CNT=3, LONG_TICKS=5, REPEAT_TICKS=2)
REQ-031 SHALL verify a clean press: key[0] goes 0 and is held -> key_level[0]=1 and a single press_pulse[0] in the cycle after the 3rd tick sampling the press.
REQ-032 SHALL verify bounce rejection: key[1] toggles 0/1 on alternate ticks for 10 ticks -> key_level[1] stays 0 with no pulses.
REQ-033 SHALL verify long press and repeat: key[2] is held -> long_pulse 5 ticks after press_pulse, then repeat_pulse every 2 ticks; on release, one release_pulse and no further repeats.
REQ-034 SHALL verify simultaneous keys: key[0] and key[2] press on the same cycle -> both press_pulse bits assert in the same clk cycle.
REQ-035 SHALL verify reset mid-hold: rst=1 for 3 cycles while in REPEAT -> all outputs 0, no release_pulse; with the key still held, press_pulse returns 3 ticks after rst falls.
